// File: rtl/tempo_regressivo_bcd_pkg.sv
// tempo_regressivo_bcd_pkg: shared FSM encoding and BCD limits for the countdown timer
package tempo_regressivo_bcd_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;
    localparam logic [3:0] BCD_MAX          = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX_DEF = 4'd5;
endpackage

// File: rtl/tempo_regressivo_bcd_digito.sv
// digito_bcd_dec: one BCD digit with clear, shift-load and borrow-chained decrement
module digito_bcd_dec
    import tempo_regressivo_bcd_pkg::*;
#(
    parameter logic [3:0] MAX = BCD_MAX
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic       dec_i,
    input  logic       bin_i,
    output logic       bout_o,
    input  logic       load_i,
    input  logic [3:0] d_i,
    input  logic       clr_i,
    output logic [3:0] q_o
);
    logic [3:0] q_q, q_d;
    assign bout_o = bin_i & (q_q == 4'd0);
    assign q_o    = q_q;
    always_comb
        q_d = clr_i ? 4'd0 :
              load_i ? d_i :
              (dec_i & bin_i) ? ((q_q == 4'd0) ? MAX : q_q - 4'd1) : q_q;
    always_ff @(posedge clk or negedge clearn)
        if (!clearn) q_q <= '0;
        else         q_q <= q_d;
endmodule

// File: rtl/tempo_regressivo_bcd.sv
// tempo_regressivo_bcd: keypad-loaded MM:SS register counting down on each synced 1 Hz edge
module tempo_regressivo_bcd
    import tempo_regressivo_bcd_pkg::*;
#(
    parameter logic [3:0] SEC_TENS_MAX = SEC_TENS_MAX_DEF,
    parameter logic [3:0] UNIT_MAX     = BCD_MAX,
    parameter int         SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic [3:0] D,
    input  logic       loadn,
    input  logic       pgt_1Hz,
    input  logic       startn,
    input  logic       stopn,
    output logic [3:0] min_t,
    output logic [3:0] min_u,
    output logic [3:0] sec_t,
    output logic [3:0] sec_u,
    output logic       running,
    output logic       zeron,
    output logic       done
);
    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] ld_sync_q, tk_sync_q;
    logic                   ld_prev_q, tk_prev_q, running_q, done_q, done_d;
    logic                   key_ev, key_ok, tick_ev, clr, load, dec, last_sec;
    logic                   b_su, b_st, b_mu, all_zero;

    assign key_ev   = ld_prev_q & ~ld_sync_q[SYNC_STAGES-1];
    assign tick_ev  = ~tk_prev_q & tk_sync_q[SYNC_STAGES-1];
    assign key_ok   = key_ev & (D <= BCD_MAX);
    assign last_sec = {min_t, min_u, sec_t, sec_u} == 16'h0001;
    assign running  = running_q;
    assign done     = done_q;
    assign zeron    = ~all_zero;

    always_ff @(posedge clk or negedge clearn)
        if (!clearn) begin
            ld_sync_q <= '1;
            tk_sync_q <= '0;
            ld_prev_q <= 1'b1;
            tk_prev_q <= 1'b0;
            state_q   <= IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            ld_sync_q <= SYNC_STAGES'({ld_sync_q, loadn});
            tk_sync_q <= SYNC_STAGES'({tk_sync_q, pgt_1Hz});
            ld_prev_q <= ld_sync_q[SYNC_STAGES-1];
            tk_prev_q <= tk_sync_q[SYNC_STAGES-1];
            state_q   <= state_d;
            running_q <= state_d == RUN;
            done_q    <= done_d;
        end

    // Stop outranks start, and both outrank a key strobe in the same cycle.
    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        load    = 1'b0;
        dec     = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE:
                if (!stopn) clr = 1'b1;
                else if (!startn && !all_zero) state_d = RUN;
                else load = key_ok;
            RUN:
                if (!stopn) state_d = PAUSE;
                else if (tick_ev) begin
                    dec = 1'b1;
                    if (last_sec) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            PAUSE:
                if (!stopn) begin
                    clr     = 1'b1;
                    state_d = IDLE;
                end else if (!startn && !all_zero) state_d = RUN;
                else load = key_ok;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    digito_bcd_dec #(.MAX(UNIT_MAX)) u_sec_u (
        .clk(clk), .clearn(clearn), .dec_i(dec), .bin_i(1'b1), .bout_o(b_su),
        .load_i(load), .d_i(D), .clr_i(clr), .q_o(sec_u)
    );
    digito_bcd_dec #(.MAX(SEC_TENS_MAX)) u_sec_t (
        .clk(clk), .clearn(clearn), .dec_i(dec), .bin_i(b_su), .bout_o(b_st),
        .load_i(load), .d_i(sec_u), .clr_i(clr), .q_o(sec_t)
    );
    digito_bcd_dec #(.MAX(UNIT_MAX)) u_min_u (
        .clk(clk), .clearn(clearn), .dec_i(dec), .bin_i(b_st), .bout_o(b_mu),
        .load_i(load), .d_i(sec_t), .clr_i(clr), .q_o(min_u)
    );
    // The last borrow-out is high exactly when every digit is zero.
    digito_bcd_dec #(.MAX(UNIT_MAX)) u_min_t (
        .clk(clk), .clearn(clearn), .dec_i(dec), .bin_i(b_mu), .bout_o(all_zero),
        .load_i(load), .d_i(min_u), .clr_i(clr), .q_o(min_t)
    );
endmodule

// File: tb/tb_tempo_regressivo_bcd.sv
// tb_tempo_regressivo_bcd: scenario tasks checked against a minutes/seconds arithmetic model
module tb_tempo_regressivo_bcd;
    logic       clk = 1'b0;
    logic       clearn = 1'b0;
    logic [3:0] D = 4'd0;
    logic       loadn = 1'b1;
    logic       pgt_1Hz = 1'b0;
    logic       startn = 1'b1;
    logic       stopn = 1'b1;
    logic [3:0] min_t, min_u, sec_t, sec_u;
    logic       running, zeron, done;
    logic [15:0] digs;
    int         n_tests = 0;
    int         n_fail = 0;
    int         done_cnt = 0;
    logic [15:0] done_digs = 16'hFFFF;
    int         m_mins = 0;
    int         m_secs = 0;
    logic [3:0] m [4];
    int         ms = 0;

    tempo_regressivo_bcd dut (
        .clk(clk), .clearn(clearn), .D(D), .loadn(loadn), .pgt_1Hz(pgt_1Hz),
        .startn(startn), .stopn(stopn), .min_t(min_t), .min_u(min_u),
        .sec_t(sec_t), .sec_u(sec_u), .running(running), .zeron(zeron), .done(done)
    );

    always #5 clk = ~clk;
    assign digs = {min_t, min_u, sec_t, sec_u};

    always @(negedge clk)
        if (done) begin
            done_cnt++;
            done_digs = digs;
        end

    function automatic logic [15:0] m_exp();
        return {m[0], m[1], m[2], m[3]};
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 4; i++) m[i] = 4'd0;
    endfunction

    function automatic void m_dec();
        m_mins = int'(m[0]) * 10 + int'(m[1]);
        m_secs = int'(m[2]) * 10 + int'(m[3]);
        if (m_secs > 0) m_secs--;
        else begin
            m_mins--;
            m_secs = 59;
        end
        m[0] = 4'(m_mins / 10);
        m[1] = 4'(m_mins % 10);
        m[2] = 4'(m_secs / 10);
        m[3] = 4'(m_secs % 10);
    endfunction

    task automatic press(input logic [3:0] d, input int hold);
        D = d;
        loadn = 1'b0;
        repeat (hold) @(negedge clk);
        loadn = 1'b1;
        repeat (4) @(negedge clk);
        if ((ms == 0 || ms == 2) && d <= 4'd9) begin
            m[0] = m[1];
            m[1] = m[2];
            m[2] = m[3];
            m[3] = d;
        end
    endtask

    task automatic tick();
        pgt_1Hz = 1'b1;
        repeat (3) @(negedge clk);
        pgt_1Hz = 1'b0;
        repeat (4) @(negedge clk);
        if (ms == 1) begin
            m_dec();
            if (m_exp() == 16'h0) ms = 0;
        end
    endtask

    task automatic start_pulse();
        startn = 1'b0;
        @(negedge clk);
        startn = 1'b1;
        repeat (2) @(negedge clk);
        if ((ms == 0 || ms == 2) && m_exp() != 16'h0) ms = 1;
    endtask

    task automatic stop_pulse();
        stopn = 1'b0;
        @(negedge clk);
        stopn = 1'b1;
        repeat (2) @(negedge clk);
        if (ms == 1) ms = 2;
        else begin
            m_clear();
            ms = 0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if (digs !== 16'h0) begin n_fail++; $display("FAIL reset_digits got=%h exp=0000", digs); end
        n_tests++;
        if (running !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_flags running=%b done=%b exp=0/0", running, done); end
        n_tests++;
        if (zeron !== 1'b0) begin n_fail++; $display("FAIL reset_zeron got=%b exp=0", zeron); end
        clearn = 1'b1;
        m_clear();
        ms = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_entry();
        press(4'd1, 3);
        press(4'd2, 5);
        press(4'd3, 4);
        press(4'd0, 6);
        n_tests++;
        if (digs !== 16'h1230 || digs !== m_exp()) begin n_fail++; $display("FAIL entry_1230 got=%h exp=1230", digs); end
        n_tests++;
        if (zeron !== 1'b1) begin n_fail++; $display("FAIL entry_zeron got=%b exp=1", zeron); end
        press(4'd7, 50);
        n_tests++;
        if (digs !== 16'h2307) begin n_fail++; $display("FAIL entry_hold got=%h exp=2307", digs); end
        press(4'hC, 5);
        n_tests++;
        if (digs !== 16'h2307) begin n_fail++; $display("FAIL entry_invalid got=%h exp=2307", digs); end
        for (int i = 0; i < 8; i++) begin
            press(4'($urandom_range(0, 15)), int'($urandom_range(3, 10)));
            n_tests++;
            if (digs !== m_exp()) begin n_fail++; $display("FAIL entry_rand%0d got=%h exp=%h", i, digs, m_exp()); end
        end
    endtask

    task automatic test_countdown();
        int base;
        stop_pulse();
        press(4'd0, 3);
        press(4'd1, 3);
        press(4'd0, 3);
        press(4'd0, 3);
        start_pulse();
        n_tests++;
        if (running !== 1'b1) begin n_fail++; $display("FAIL cd_running got=%b exp=1", running); end
        tick();
        n_tests++;
        if (digs !== 16'h0059 || digs !== m_exp()) begin n_fail++; $display("FAIL cd_borrow got=%h exp=0059", digs); end
        base = done_cnt;
        for (int i = 0; i < 59; i++) begin
            tick();
            n_tests++;
            if (digs !== m_exp()) begin n_fail++; $display("FAIL cd_tick%0d got=%h exp=%h", i, digs, m_exp()); end
        end
        n_tests++;
        if (done_cnt - base !== 1 || done_digs !== 16'h0) begin
            n_fail++;
            $display("FAIL cd_done pulses=%0d at=%h exp=1 at 0000", done_cnt - base, done_digs);
        end
        n_tests++;
        if (running !== 1'b0 || zeron !== 1'b0) begin n_fail++; $display("FAIL cd_end running=%b zeron=%b exp=0/0", running, zeron); end
        press(4'd4, 3);
        n_tests++;
        if (digs !== 16'h0004) begin n_fail++; $display("FAIL cd_idle_after got=%h exp=0004", digs); end
    endtask

    task automatic test_zero_start();
        stop_pulse();
        start_pulse();
        n_tests++;
        if (digs !== 16'h0 || running !== 1'b0 || zeron !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_start digits=%h running=%b zeron=%b exp=0000/0/0", digs, running, zeron);
        end
    endtask

    task automatic test_pause();
        press(4'd1, 3);
        press(4'd0, 3);
        start_pulse();
        pgt_1Hz = 1'b1;
        repeat (2) @(negedge clk);
        stopn = 1'b0;
        @(negedge clk);
        stopn = 1'b1;
        repeat (2) @(negedge clk);
        pgt_1Hz = 1'b0;
        repeat (4) @(negedge clk);
        ms = 2;
        n_tests++;
        if (digs !== 16'h0010 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_priority digits=%h running=%b exp=0010/0", digs, running);
        end
        tick();
        n_tests++;
        if (digs !== 16'h0010) begin n_fail++; $display("FAIL pause_tick got=%h exp=0010", digs); end
        press(4'd5, 4);
        n_tests++;
        if (digs !== 16'h0105) begin n_fail++; $display("FAIL pause_key got=%h exp=0105", digs); end
        start_pulse();
        tick();
        n_tests++;
        if (digs !== 16'h0104 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_resume digits=%h running=%b exp=0104/1", digs, running);
        end
    endtask

    task automatic test_async_reset();
        stop_pulse();
        stop_pulse();
        press(4'd1, 3);
        press(4'd3, 3);
        press(4'd0, 3);
        start_pulse();
        n_tests++;
        if (digs !== 16'h0130 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_setup digits=%h running=%b exp=0130/1", digs, running);
        end
        #2 clearn = 1'b0;
        #1;
        n_tests++;
        if (digs !== 16'h0 || running !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_async digits=%h running=%b done=%b exp=0000/0/0", digs, running, done);
        end
        @(negedge clk);
        clearn = 1'b1;
        m_clear();
        ms = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        int base;
        int exp_done;
        int op;
        base = done_cnt;
        exp_done = 0;
        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 9));
            if (op <= 3) press(4'($urandom_range(0, 15)), int'($urandom_range(3, 8)));
            else if (op <= 6 || (op != 8 && m_exp() == 16'h0)) begin
                if (ms == 1 && m_exp() == 16'h0001) exp_done++;
                tick();
            end else if (op == 8) stop_pulse();
            else start_pulse();
            n_tests++;
            if (digs !== m_exp() || running !== (ms == 1)) begin
                n_fail++;
                $display("FAIL rand%0d op=%0d digits=%h running=%b exp=%h/%b", i, op, digs, running, m_exp(), ms == 1);
            end
        end
        n_tests++;
        if (done_cnt - base !== exp_done) begin n_fail++; $display("FAIL rand_done got=%0d exp=%0d", done_cnt - base, exp_done); end
    endtask

    initial begin
        m_clear();
        test_reset();
        test_entry();
        test_countdown();
        test_zero_start();
        test_pause();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
